// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address: up to 4 bytes received into RDR per write,
// up to 4 bytes sent from TDR per read, behind a 32-bit peripheral register interface.
module i2c_slave #(
    parameter logic [6:0]  ADDR_RST = 7'h50,
    parameter int unsigned SYNC_FF  = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_i,
    input  logic [3:0]  data_be_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    inout  wire         sda_io,
    input  logic        scl_io
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_AACK, S_WRX, S_WACK, S_TX, S_RACK, S_WAITP, S_IGNORE
    } state_t;

    state_t             r_state;
    logic [SYNC_FF-1:0] r_scl_sync, r_sda_sync;
    logic               r_scl_q, r_sda_q;
    logic [6:0]         r_adr;
    logic [31:0]        r_tdr, r_rdr;
    logic [2:0]         r_tnb, r_rcnt;
    logic               r_rxd, r_txd, r_ovf, r_busy;
    logic               r_sda_low;
    logic [2:0]         r_bit_cnt;
    logic [6:0]         r_shift;
    logic               r_rw, r_matched, r_ack_on;
    logic [1:0]         r_ptr;
    logic               r_ptr_uf;

    logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte, w_tx_byte, w_init_byte;
    logic [2:0] w_tnb_eff;
    logic [1:0] w_ptr_init;

    assign w_scl      = r_scl_sync[SYNC_FF-1];
    assign w_sda      = r_sda_sync[SYNC_FF-1];
    assign w_scl_rise = w_scl & ~r_scl_q;
    assign w_scl_fall = ~w_scl & r_scl_q;
    assign w_start    = w_scl & r_scl_q & r_sda_q & ~w_sda;
    assign w_stop     = w_scl & r_scl_q & ~r_sda_q & w_sda;
    assign w_byte     = {r_shift, w_sda};

    // Byte pointer: TNB of 0 means 1, anything above 4 means 4
    always_comb begin
        w_tnb_eff = r_tnb;
        if (r_tnb == 3'd0)
            w_tnb_eff = 3'd1;
        else if (r_tnb > 3'd4)
            w_tnb_eff = 3'd4;
    end
    assign w_ptr_init  = 2'(w_tnb_eff - 3'd1);
    assign w_init_byte = r_tdr[{w_ptr_init, 3'b000} +: 8];
    assign w_tx_byte   = r_ptr_uf ? 8'hFF : r_tdr[{r_ptr, 3'b000} +: 8];

    // Open drain: release immediately while reset is held
    assign sda_io = (r_sda_low && !rst_i) ? 1'b0 : 1'bz;

    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            5'h00:   rdata_o = {25'd0, r_adr};
            5'h04:   rdata_o = r_tdr;
            5'h08:   rdata_o = r_rdr;
            5'h0C:   rdata_o = {20'd0, r_busy, r_ovf, r_txd, r_rxd, 1'b0, r_rcnt, 1'b0, r_tnb};
            default: rdata_o = 32'd0;
        endcase
    end

    // Bus writes first so that flag sets from the bus FSM below override w1c clears
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
            r_adr      <= ADDR_RST;
            r_tdr      <= 32'd0;
            r_rdr      <= 32'd0;
            r_tnb      <= 3'd4;
            r_rcnt     <= 3'd0;
            r_rxd      <= 1'b0;
            r_txd      <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_low  <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_matched  <= 1'b0;
            r_ack_on   <= 1'b0;
            r_ptr      <= 2'd0;
            r_ptr_uf   <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_FF-2:0], scl_io};
            r_sda_sync <= {r_sda_sync[SYNC_FF-2:0], sda_io};
            r_scl_q    <= w_scl;
            r_sda_q    <= w_sda;

            if (write_i) begin
                case (addr_i)
                    5'h00: if (data_be_i[0]) r_adr <= wdata_i[6:0];
                    5'h04: begin
                        for (int b = 0; b < 4; b++)
                            if (data_be_i[b]) r_tdr[8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                    5'h0C: begin
                        if (data_be_i[0]) r_tnb <= wdata_i[2:0];
                        if (data_be_i[1]) begin
                            if (wdata_i[8])  r_rxd <= 1'b0;
                            if (wdata_i[9])  r_txd <= 1'b0;
                            if (wdata_i[10]) r_ovf <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_start) begin
                r_state   <= S_ADDR;
                r_sda_low <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_matched <= 1'b0;
                r_busy    <= 1'b0;
                r_ack_on  <= 1'b0;
            end else if (w_stop) begin
                if (r_state != S_IDLE) begin
                    r_state   <= S_IDLE;
                    r_sda_low <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ack_on  <= 1'b0;
                    r_matched <= 1'b0;
                    if (r_matched && !r_rw && r_rcnt != 3'd0) r_rxd <= 1'b1;
                    if (r_matched && r_rw) r_txd <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (w_byte[7:1] == r_adr) begin
                                r_state   <= S_AACK;
                                r_busy    <= 1'b1;
                                r_matched <= 1'b1;
                                r_rw      <= w_byte[0];
                                r_ack_on  <= 1'b0;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end
                    end
                    S_AACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_low <= 1'b1;
                            r_ack_on  <= 1'b1;
                        end else begin
                            r_ack_on <= 1'b0;
                            if (r_rw) begin
                                r_state   <= S_TX;
                                r_ptr     <= w_ptr_init;
                                r_ptr_uf  <= 1'b0;
                                r_bit_cnt <= 3'd7;
                                r_sda_low <= ~w_init_byte[7];
                            end else begin
                                r_state   <= S_WRX;
                                r_rdr     <= 32'd0;
                                r_rcnt    <= 3'd0;
                                r_bit_cnt <= 3'd0;
                                r_sda_low <= 1'b0;
                            end
                        end
                    end
                    S_WRX: if (w_scl_rise) begin
                        r_shift   <= w_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rdr    <= {r_rdr[23:0], w_byte};
                            r_state  <= S_WACK;
                            r_ack_on <= 1'b0;
                            if (r_rcnt == 3'd4) r_ovf  <= 1'b1;
                            else                r_rcnt <= r_rcnt + 3'd1;
                        end
                    end
                    S_WACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_low <= 1'b1;
                            r_ack_on  <= 1'b1;
                        end else begin
                            r_ack_on  <= 1'b0;
                            r_sda_low <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_WRX;
                        end
                    end
                    S_TX: if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_sda_low <= 1'b0;
                            r_ack_on  <= 1'b0;
                            r_state   <= S_RACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_sda_low <= ~w_tx_byte[r_bit_cnt - 3'd1];
                        end
                    end
                    // r_ack_on marks a received ACK; the next byte starts on the following fall
                    S_RACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= S_WAITP;
                            end else begin
                                r_ack_on <= 1'b1;
                                if (r_ptr == 2'd0) r_ptr_uf <= 1'b1;
                                else               r_ptr    <= r_ptr - 2'd1;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on  <= 1'b0;
                            r_state   <= S_TX;
                            r_bit_cnt <= 3'd7;
                            r_sda_low <= ~w_tx_byte[7];
                        end
                    end
                    default: r_sda_low <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master plus register-bus accesses.
module tb_i2c_slave;
    localparam int unsigned Q = 50;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        write_i;
    logic [3:0]  data_be_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        scl;
    logic        m_sda_low;
    wire         sda;

    int n_checks = 0;
    int n_errors = 0;
    int slave_low_cnt = 0;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave #(.ADDR_RST(7'h50), .SYNC_FF(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .write_i   (write_i),
        .data_be_i (data_be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .sda_io    (sda),
        .scl_io    (scl)
    );

    always #5 clk = ~clk;

    // Counts cycles where SDA is low without the master pulling it
    always @(posedge clk) if (sda == 1'b0 && !m_sda_low) slave_low_cnt <= slave_low_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        write_i = 1'b1; addr_i = a; wdata_i = d; data_be_i = be;
        @(negedge clk);
        write_i = 1'b0; data_be_i = 4'd0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = a;
        #1 d = rdata_o;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q(); wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; wait_q();
        scl = 1'b1;     wait_q(); wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        b = sda;          wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  rb;
        logic        ack;
        logic [7:0]  wbytes [5];
        int          low_before;

        rst_i = 1'b1; write_i = 1'b0; data_be_i = 4'd0; addr_i = 5'd0; wdata_i = 32'd0;
        scl = 1'b1; m_sda_low = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        bus_read(5'h00, rd); check("rst_adr", rd, 32'h50);
        bus_read(5'h04, rd); check("rst_tdr", rd, 32'h0);
        bus_read(5'h08, rd); check("rst_rdr", rd, 32'h0);
        bus_read(5'h0C, rd); check("rst_sts", rd, 32'h004);
        check("rst_sda", 32'(sda), 32'h1);

        bus_write(5'h00, 32'h0000_002A, 4'b0001);
        bus_read(5'h00, rd); check("adr_rw", rd, 32'h2A);
        bus_write(5'h04, 32'hFFFF_FFFF, 4'b0010);
        bus_read(5'h04, rd); check("tdr_be", rd, 32'h0000_FF00);
        bus_write(5'h08, 32'hDEAD_BEEF, 4'b1111);
        bus_read(5'h08, rd); check("rdr_ro", rd, 32'h0);

        // Write of three bytes
        i2c_start();
        write_byte(8'h54, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack); check("wr_b0_ack", 32'(ack), 32'h0);
        write_byte(8'h22, ack); check("wr_b1_ack", 32'(ack), 32'h0);
        write_byte(8'h33, ack); check("wr_b2_ack", 32'(ack), 32'h0);
        bus_read(5'h0C, rd); check("wr_busy", rd, 32'h834);
        i2c_stop();
        bus_read(5'h08, rd); check("wr_rdr", rd, 32'h0011_2233);
        bus_read(5'h0C, rd); check("wr_sts", rd, 32'h134);
        bus_write(5'h0C, 32'h0000_0100, 4'b0010);
        bus_read(5'h0C, rd); check("rxd_w1c", rd, 32'h034);

        // Read of two bytes, NACK on the second
        bus_write(5'h04, 32'hA1B2_C3D4, 4'b1111);
        bus_write(5'h0C, 32'h0000_0002, 4'b0001);
        bus_read(5'h0C, rd); check("tnb_wr", rd, 32'h032);
        i2c_start();
        write_byte(8'h55, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        read_byte(rb, 1'b0); check("rd_b0", 32'(rb), 32'hC3);
        read_byte(rb, 1'b1); check("rd_b1", 32'(rb), 32'hD4);
        i2c_stop();
        bus_read(5'h0C, rd); check("rd_sts", rd, 32'h232);
        bus_write(5'h0C, 32'h0000_0200, 4'b0010);
        bus_read(5'h0C, rd); check("txd_w1c", rd, 32'h032);

        // Address mismatch: no ACK, nothing changes
        low_before = slave_low_cnt;
        i2c_start();
        write_byte(8'h56, ack); check("mm_addr_nack", 32'(ack), 32'h1);
        write_byte(8'h99, ack); check("mm_data_nack", 32'(ack), 32'h1);
        i2c_stop();
        check("mm_sda_low", 32'(slave_low_cnt - low_before), 32'h0);
        bus_read(5'h08, rd); check("mm_rdr", rd, 32'h0011_2233);
        bus_read(5'h0C, rd); check("mm_sts", rd, 32'h032);

        // Five-byte write overflows
        wbytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        i2c_start();
        write_byte(8'h54, ack); check("ov_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 5; i++) begin
            write_byte(wbytes[i], ack);
            check($sformatf("ov_b%0d_ack", i), 32'(ack), 32'h0);
        end
        i2c_stop();
        bus_read(5'h08, rd); check("ov_rdr", rd, 32'h0203_0405);
        bus_read(5'h0C, rd); check("ov_sts", rd, 32'h542);
        bus_write(5'h0C, 32'h0000_0400, 4'b0010);
        bus_read(5'h0C, rd); check("ovf_w1c", rd, 32'h142);

        // Reset in the middle of a read byte while the target holds SDA low
        bus_write(5'h0C, 32'h0000_0004, 4'b0001);
        i2c_start();
        write_byte(8'h55, ack); check("rr_addr_ack", 32'(ack), 32'h0);
        read_bit(ack); check("rr_bit7", 32'(ack), 32'h1);
        check("rr_bit6_drv", 32'(sda), 32'h0);
        rst_i = 1'b1;
        @(negedge clk);
        check("rr_sda_rel", 32'(sda), 32'h1);
        @(negedge clk);
        rst_i = 1'b0;
        bus_read(5'h0C, rd); check("rr_sts", rd, 32'h004);
        bus_read(5'h04, rd); check("rr_tdr", rd, 32'h0);
        bus_read(5'h00, rd); check("rr_adr", rd, 32'h50);
        i2c_stop();

        // Normal transfer after reset at the reset address
        i2c_start();
        write_byte(8'hA0, ack); check("pr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h5A, ack); check("pr_b0_ack", 32'(ack), 32'h0);
        i2c_stop();
        bus_read(5'h08, rd); check("pr_rdr", rd, 32'h0000_005A);
        bus_read(5'h0C, rd); check("pr_sts", rd, 32'h114);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
